// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states, datapath width.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: add/sub with carry-out (borrow on sub) plus six bitwise ops.
// Latency: zero cycles. Backpressure: none, pure logic.
// Carry is only meaningful for ADD/SUB; the caller masks it for logic ops.
module alu_8bit
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] result,
    output logic         carry
);

    logic [W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[W-1:0];
                carry  = sum[W];
            end
            OP_SUB: begin
                // Bit W of the widened difference is set exactly when a < b.
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[W-1:0];
                carry  = sum[W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Latency: accept at T, response valid from T+2; minimum issue interval 3 cycles.
// Backpressure: holds RESP with stable outputs until rsp_ready; requests wait outside IDLE.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              busy
);

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic              id_q;

    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    alu_8bit #(.W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= grant_id ? req1_a  : req0_a;
                        b_q        <= grant_id ? req1_b  : req0_b;
                        op_q       <= grant_id ? req1_op : req0_op;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry && is_arith(op_q);
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares a single 8-bit ALU datapath between two requesters. It accepts one operation at a time over a valid/ready request handshake, registers the operands, executes the operation, and returns the result and carry on a shared valid/ready response channel tagged with the requester ID. It sits between the two client blocks and the ALU datapath, which it instantiates.

## Interface
Parameters:
- DATA_W, 8, operand/result width; only 8 is supported.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0's operation is accepted this cycle
- req0_a, req0_b  in  8  requester 0 operands
- req0_op  in  3  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, for requester 1
- rsp_valid  out  1  response holding
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  8  ALU result
- rsp_carry  out  1  carry/borrow flag
- busy  out  1  FSM not in IDLE

## Operation
- Opcodes (3 bits):
  - 000 ADD: {carry,result} = A+B, 9-bit.
  - 001 SUB: {carry,result} = A−B, 9-bit two's complement. Carry=1 means borrow (A<B).
  - 010 AND, 011 OR, 100 XOR, 101 NOR, 110 NAND, 111 XNOR. Carry=0 for all logic ops; it is never held from a previous op.
- FSM states are IDLE, EXEC and RESP.
  - IDLE: if any reqN_valid, grant one requester and raise its reqN_ready combinationally in the same cycle. Capture a, b, op and id into registers, then go to EXEC.
  - EXEC: the ALU evaluates the registered operands. Result and carry are registered into rsp_result/rsp_carry, then go to RESP.
  - RESP: rsp_valid=1, with rsp_id, rsp_result and rsp_carry stable. On rsp_ready go to IDLE. Otherwise stay, holding all response outputs unchanged.
- Arbitration:
  - A 1-bit last_grant register selects between requesters.
  - If only one requester is valid, it wins.
  - If both are valid, the requester ≠ last_grant wins.
  - last_grant updates only on acceptance.
  - Reset value of last_grant is 1, so requester 0 wins the first tie.
- reqN_ready is 0 outside IDLE and for the losing requester. At most one ready is high per cycle.
- Requesters must hold valid and operands stable until ready. A valid that drops before ready is simply not served.

## Timing
- Acceptance in cycle T gives EXEC at T+1 and rsp_valid=1 from T+2.
- Minimum issue interval is 3 cycles (RESP with rsp_ready=1 returns to IDLE). Next acceptance is no earlier than T+3.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0x00, rsp_carry=0, busy=0, state=IDLE, last_grant=1.
- req0_ready and req1_ready are 0 while rst_n=0.
- Reset asserted mid-operation (EXEC or RESP) drops the transaction immediately: rsp_valid goes 0 asynchronously and no response is ever produced.
- A request arriving during EXEC/RESP waits. It is arbitrated in the first IDLE cycle.
- Simultaneous rsp_ready and new requests in RESP: the response completes, and the new request is accepted in the following IDLE cycle.
- rsp_ready while rsp_valid=0 is ignored.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD…OP_XNOR (3'b000–3'b111)
  - FSM state encoding (IDLE, EXEC, RESP)
  - DATA_W default
- Sub-module: alu_8bit, the combinational ALU, instantiated once and fed from the operand registers. The arbiter forces carry=0 for logic opcodes.
- Everything else (arbiter, FSM, operand/response registers) lives in alu_arbiter.

## Test plan
- Single ADD: req0 a=0xF0, b=0x20, op=000. Expect accept at T, and at T+2 rsp_valid=1, id=0, result=0x10, carry=1.
- SUB with borrow: req1 a=0x05, b=0x0A, op=001. Expect result=0xFB, carry=1, id=1. Then a=0x0A, b=0x05 gives 0x05, carry=0.
- Fairness: both valid continuously for 6 operations. Grants must be 0,1,0,1,0,1, each response carrying the matching id.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Outputs must stay stable, both readies stay 0, and busy=1. Release gives return to IDLE the next cycle.
- Logic ops: a=0xA5, b=0x0F. Expect XNOR 0x55, NAND 0xFA, NOR 0x50, AND 0x05, OR 0xAF, XOR 0xAA. Carry=0 for each, including directly after an ADD that produced carry=1.
- Reset mid-op: assert rst_n=0 during EXEC. Expect rsp_valid=0 and all outputs at reset values. After release, a tie must grant requester 0.
